// File: rtl/hc595_chain_driver_if.sv
// Bundle of the user-side handshake and the 595 pin signals for hc595_chain_driver.
// The master side is the display/LED logic; the slave side is the chain driver.
interface hc595_chain_driver_if #(
   parameter int NBITS = 16
);
   logic [NBITS-1:0] data;
   logic             start;
   logic             auto_en;
   logic             busy;
   logic             done;
   logic             SH_CP;
   logic             ST_CP;
   logic             DS;

   modport master (
      output data, start, auto_en,
      input  busy, done, SH_CP, ST_CP, DS
   );

   modport slave (
      input  data, start, auto_en,
      output busy, done, SH_CP, ST_CP, DS
   );
endinterface

// File: rtl/hc595_chain_driver.sv
// Serial driver for a daisy chain of NUM_CHIPS 74HC595 shift registers.
// Shifts an NBITS word out on DS/SH_CP, then pulses ST_CP to latch it.
// Offers a start/busy/done handshake, a one-deep pending update buffer
// (latest request wins) and an auto-refresh mode that retransmits data
// whenever the driver would otherwise go idle.
module hc595_chain_driver #(
   parameter int NUM_CHIPS = 2,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   hc595_chain_driver_if.slave bus
);

   localparam int NBITS = 8 * NUM_CHIPS;
   localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int DW    = $clog2(CLK_DIV) + 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t           state_reg;
   // Remaining bits of the word in flight, already in transmit order. The
   // first bit goes straight to DS on load, so only NBITS-1 bits are kept.
   logic [NBITS-2:0] shadow_reg;
   // Pending update, stored already in transmit order.
   logic [NBITS-1:0] pend_buf_reg;
   logic             pending_reg;
   logic [DW-1:0]    div_cnt_reg;
   logic [BW-1:0]    bit_cnt_reg;
   logic             sh_cp_reg;
   logic             st_cp_reg;
   logic             ds_reg;
   logic             busy_reg;
   logic             done_reg;

   // Input word rearranged so that bit NBITS-1 is always the first one shifted.
   logic [NBITS-1:0] ord_data;

   genvar gi;
   generate
      for (gi = 0; gi < NBITS; gi++) begin : g_order
         if (MSB_FIRST != 0) begin : g_msb
            assign ord_data[gi] = bus.data[gi];
         end else begin : g_lsb
            assign ord_data[gi] = bus.data[NBITS-1-gi];
         end
      end
   endgenerate

   logic             div_wrap;
   logic             do_load;
   logic [NBITS-1:0] load_word;

   // Decide when a new transfer begins and which word it carries. A start
   // arriving on the LATCH exit cycle is newer than the buffer, so it wins.
   always_comb begin
      div_wrap  = (div_cnt_reg == DIV_LAST);
      do_load   = 1'b0;
      load_word = ord_data;
      case (state_reg)
         IDLE: begin
            do_load = bus.start | bus.auto_en;
         end
         LATCH: begin
            do_load = div_wrap & (pending_reg | bus.start | bus.auto_en);
            if (pending_reg && !bus.start) begin
               load_word = pend_buf_reg;
            end
         end
         default: begin
            do_load = 1'b0;
         end
      endcase
   end

   // Transfer FSM: shift clock generation, bit sequencing, latch pulse and handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         shadow_reg   <= '0;
         pend_buf_reg <= '0;
         pending_reg  <= 1'b0;
         div_cnt_reg  <= '0;
         bit_cnt_reg  <= '0;
         sh_cp_reg    <= 1'b0;
         st_cp_reg    <= 1'b0;
         ds_reg       <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         // Requests while busy go to the one-deep buffer; a newer one overwrites it.
         if (state_reg != IDLE && bus.start) begin
            pend_buf_reg <= ord_data;
            pending_reg  <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               div_cnt_reg <= '0;
            end

            SHIFT: begin
               if (div_wrap) begin
                  div_cnt_reg <= '0;
                  if (!sh_cp_reg) begin
                     // End of low phase: the 595 samples DS on this rising edge.
                     sh_cp_reg <= 1'b1;
                  end else begin
                     // End of high phase: DS only moves with the falling edge.
                     sh_cp_reg <= 1'b0;
                     if (bit_cnt_reg == BIT_LAST) begin
                        st_cp_reg <= 1'b1;
                        state_reg <= LATCH;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + BW'(1);
                        ds_reg      <= shadow_reg[NBITS-2];
                        shadow_reg  <= {shadow_reg[NBITS-3:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + DW'(1);
               end
            end

            LATCH: begin
               if (div_wrap) begin
                  div_cnt_reg <= '0;
                  st_cp_reg   <= 1'b0;
                  done_reg    <= 1'b1;
                  if (!do_load) begin
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + DW'(1);
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase

         // Common setup for every new transfer, from IDLE or straight out of LATCH.
         // The buffer is consumed by this load whether it or a fresh start supplied it.
         if (do_load) begin
            ds_reg      <= load_word[NBITS-1];
            shadow_reg  <= load_word[NBITS-2:0];
            sh_cp_reg   <= 1'b0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
            if (state_reg == LATCH) begin
               pending_reg <= 1'b0;
            end
         end
      end
   end

   assign bus.SH_CP = sh_cp_reg;
   assign bus.ST_CP = st_cp_reg;
   assign bus.DS    = ds_reg;
   assign bus.busy  = busy_reg;
   assign bus.done  = done_reg;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver: two instances (default 16-bit MSB-first /4 and a
// 24-bit LSB-first /1 chain), a behavioural 595 chain model on each, and a
// scoreboard of expected latched words popped on every ST_CP rising edge.
module tb_hc595_chain_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hc595_chain_driver_if #(.NBITS(16)) bus_a ();
   hc595_chain_driver_if #(.NBITS(24)) bus_b ();

   hc595_chain_driver #(.NUM_CHIPS(2), .CLK_DIV(4), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a)
   );
   hc595_chain_driver #(.NUM_CHIPS(3), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] rev24(input logic [23:0] w);
      logic [23:0] r;
      for (int i = 0; i < 24; i++) r[i] = w[23-i];
      return r;
   endfunction

   // Scoreboards of words expected to appear on the 595 outputs, in order.
   logic [15:0] q_a[$];
   logic [23:0] q_b[$];

   // Chain model and event statistics.
   int cyc = 0;
   logic [15:0] chain_a = '0, latched_a = '0, ds_log_a = '0;
   logic [23:0] chain_b = '0, latched_b = '0, ds_log_b = '0;
   logic psh_a = 0, pst_a = 0, pbusy_a = 0, psh_b = 0, pst_b = 0, pbusy_b = 0;
   int rise_a = 0, tx_rises_a = 0, last_rise_a = 0, gap_err_a = 0;
   int latch_a = 0, st_rise_a = 0, st_width_a = 0;
   int done_a = 0, last_done_a = 0, done_gap_a = 0;
   int busy_rise_a = 0, busy_len_a = 0, busy_fall_a = 0;
   int rise_b = 0, latch_b = 0, done_b = 0, busy_rise_b = 0, busy_len_b = 0;

   // Monitor: sample pins on the falling edge, model the 595s, pop the scoreboard on latch.
   always @(negedge clk) begin
      logic [15:0] exp_a;
      logic [23:0] exp_b;
      cyc++;
      if (!rst_n) tx_rises_a = 0;
      if (bus_a.SH_CP && !psh_a) begin
         chain_a  = {chain_a[14:0], bus_a.DS};
         ds_log_a = {ds_log_a[14:0], bus_a.DS};
         if (tx_rises_a > 0 && (cyc - last_rise_a) != 8) gap_err_a++;
         tx_rises_a++;
         rise_a++;
         last_rise_a = cyc;
      end
      if (bus_a.ST_CP && !pst_a) begin
         latched_a = chain_a;
         latch_a++;
         st_rise_a = cyc;
         if (q_a.size() > 0) begin
            exp_a = q_a.pop_front();
            check("sb_latch_a", latched_a, exp_a);
         end else begin
            check("sb_a_unexpected_latch", q_a.size(), 1);
         end
      end
      if (!bus_a.ST_CP && pst_a) st_width_a = cyc - st_rise_a;
      if (bus_a.done) begin
         done_a++;
         done_gap_a = cyc - last_done_a;
         last_done_a = cyc;
         tx_rises_a = 0;
      end
      if (bus_a.busy && !pbusy_a) busy_rise_a = cyc;
      if (!bus_a.busy && pbusy_a) begin
         busy_len_a = cyc - busy_rise_a;
         busy_fall_a++;
      end
      psh_a = bus_a.SH_CP;
      pst_a = bus_a.ST_CP;
      pbusy_a = bus_a.busy;

      if (bus_b.SH_CP && !psh_b) begin
         chain_b  = {chain_b[22:0], bus_b.DS};
         ds_log_b = {ds_log_b[22:0], bus_b.DS};
         rise_b++;
      end
      if (bus_b.ST_CP && !pst_b) begin
         latched_b = chain_b;
         latch_b++;
         if (q_b.size() > 0) begin
            exp_b = q_b.pop_front();
            check("sb_latch_b", latched_b, exp_b);
         end else begin
            check("sb_b_unexpected_latch", q_b.size(), 1);
         end
      end
      if (bus_b.done) done_b++;
      if (bus_b.busy && !pbusy_b) busy_rise_b = cyc;
      if (!bus_b.busy && pbusy_b) busy_len_b = cyc - busy_rise_b;
      psh_b = bus_b.SH_CP;
      pst_b = bus_b.ST_CP;
      pbusy_b = bus_b.busy;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_a(input logic [15:0] w);
      bus_a.data = w;
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
   endtask

   task automatic pulse_b(input logic [23:0] w);
      bus_b.data = w;
      bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
   endtask

   // Bounded wait until the done count of instance sel reaches target.
   task automatic wait_done(input int sel, input int target, input int budget, input string tag);
      int k = 0;
      while (((sel == 0) ? done_a : done_b) < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, (((sel == 0) ? done_a : done_b) >= target), 1);
   endtask

   int b_rise, b_done, b_gap, b_latch, b_fall;
   logic [15:0] saved;

   initial begin
      bus_a.data = '0; bus_a.start = 0; bus_a.auto_en = 0;
      bus_b.data = '0; bus_b.start = 0; bus_b.auto_en = 0;
      tick(5);
      check("rst_outs_a", {bus_a.SH_CP, bus_a.ST_CP, bus_a.DS, bus_a.busy, bus_a.done}, 0);
      check("rst_outs_b", {bus_b.SH_CP, bus_b.ST_CP, bus_b.DS, bus_b.busy, bus_b.done}, 0);
      rst_n = 1'b1;
      tick(2);

      // 1: default single transfer of A55A
      check("t1_idle_busy", bus_a.busy, 0);
      b_rise = rise_a; b_done = done_a; b_gap = gap_err_a; b_latch = latch_a;
      q_a.push_back(16'hA55A);
      pulse_a(16'hA55A);
      check("t1_busy_rise", bus_a.busy, 1);
      wait_done(0, b_done + 1, 300, "t1_done_seen");
      tick(3);
      check("t1_busy_len", busy_len_a, 132);
      check("t1_rises", rise_a - b_rise, 16);
      check("t1_rise_gap_err", gap_err_a - b_gap, 0);
      check("t1_ds_bits", ds_log_a, 16'hA55A);
      check("t1_st_width", st_width_a, 4);
      check("t1_done_cnt", done_a - b_done, 1);
      check("t1_latch_cnt", latch_a - b_latch, 1);
      check("t1_chain", latched_a, 16'hA55A);

      // 2: LSB-first, 3 chips, CLK_DIV=1
      b_rise = rise_b; b_done = done_b;
      q_b.push_back(rev24(24'h000001));
      pulse_b(24'h000001);
      wait_done(1, b_done + 1, 200, "t2_done_seen");
      tick(3);
      check("t2_busy_len", busy_len_b, 49);
      check("t2_rises", rise_b - b_rise, 24);
      check("t2_ds_bits", ds_log_b, 24'h800000);
      check("t2_done_cnt", done_b - b_done, 1);

      // 3: pending buffer, latest request wins
      b_done = done_a; b_fall = busy_fall_a; b_gap = gap_err_a;
      q_a.push_back(16'h1234);
      q_a.push_back(16'h0F0F);
      pulse_a(16'h1234);
      tick(19);
      pulse_a(16'hFFFF);
      tick(19);
      pulse_a(16'h0F0F);
      wait_done(0, b_done + 2, 600, "t3_done_seen");
      tick(3);
      check("t3_done_cnt", done_a - b_done, 2);
      check("t3_busy_falls", busy_fall_a - b_fall, 1);
      check("t3_busy_len", busy_len_a, 264);
      check("t3_rise_gap_err", gap_err_a - b_gap, 0);
      check("t3_chain", latched_a, 16'h0F0F);

      // 4: auto refresh with a data change between transactions
      b_done = done_a; b_fall = busy_fall_a; b_latch = latch_a;
      q_a.push_back(16'h1111);
      q_a.push_back(16'h2222);
      q_a.push_back(16'h2222);
      bus_a.data = 16'h1111;
      bus_a.auto_en = 1'b1;
      tick(60);
      bus_a.data = 16'h2222;
      wait_done(0, b_done + 2, 400, "t4_second_done");
      bus_a.auto_en = 1'b0;
      wait_done(0, b_done + 3, 300, "t4_third_done");
      tick(3);
      check("t4_done_cnt", done_a - b_done, 3);
      check("t4_latch_cnt", latch_a - b_latch, 3);
      check("t4_busy_falls", busy_fall_a - b_fall, 1);
      check("t4_done_gap", done_gap_a, 132);
      check("t4_busy_len", busy_len_a, 396);
      check("t4_idle", bus_a.busy, 0);

      // 6: start and auto_en together in IDLE give one transaction
      b_done = done_a; b_latch = latch_a;
      q_a.push_back(16'h5AA5);
      bus_a.data = 16'h5AA5;
      bus_a.start = 1'b1;
      bus_a.auto_en = 1'b1;
      tick(1);
      bus_a.start = 1'b0;
      tick(50);
      bus_a.auto_en = 1'b0;
      wait_done(0, b_done + 1, 300, "t6_done_seen");
      tick(150);
      check("t6_done_cnt", done_a - b_done, 1);
      check("t6_latch_cnt", latch_a - b_latch, 1);
      check("t6_busy_len", busy_len_a, 132);
      check("t6_idle", bus_a.busy, 0);

      // 5: reset in the middle of a transfer
      saved = latched_a;
      b_latch = latch_a;
      pulse_a(16'h00FF);
      tick(49);
      rst_n = 1'b0;
      tick(1);
      check("t5_rst_outs", {bus_a.SH_CP, bus_a.ST_CP, bus_a.DS, bus_a.busy, bus_a.done}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(150);
      check("t5_no_latch", latch_a - b_latch, 0);
      check("t5_chain_kept", latched_a, saved);
      check("t5_idle", bus_a.busy, 0);
      b_done = done_a;
      q_a.push_back(16'hC3C3);
      pulse_a(16'hC3C3);
      wait_done(0, b_done + 1, 300, "t5_done_seen");
      tick(3);
      check("t5_busy_len", busy_len_a, 132);
      check("t5_chain", latched_a, 16'hC3C3);

      check("sb_a_drained", q_a.size(), 0);
      check("sb_b_drained", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
Parametrised serial driver for a daisy-chain of NUM_CHIPS 74HC595 shift registers. It generalises the fixed 16-bit seg/sel driver to any chain length, selectable bit order and clock rate. It adds a start/busy/done handshake, a one-deep pending-update buffer and an auto-refresh mode. It sits between display or LED logic and the board pins SH_CP, ST_CP and DS.

Parameters:
NUM_CHIPS, 2, number of cascaded 595s; NBITS = 8*NUM_CHIPS; must be >= 1
CLK_DIV, 4, clk cycles per SH_CP half-period and per ST_CP high time; must be >= 1
MSB_FIRST, 1, 1: data[NBITS-1] shifted first; 0: data[0] shifted first

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
data  input  NBITS  parallel word; first-shifted bit lands in the farthest chip
start  input  1  single-cycle update request
auto_en  input  1  1: retransmit data continuously whenever idle
busy  output  1  high while a transaction is in progress
done  output  1  one-cycle pulse when ST_CP falls
SH_CP  output  1  shift clock to the 595 chain
ST_CP  output  1  storage/latch clock
DS  output  1  serial data

Behaviour:
- One clock; reset is synchronous, active-low, on clk rising edge (rst_n).
- Reset values: SH_CP=0, ST_CP=0, DS=0, busy=0, done=0. State=IDLE; pending flag, counters and shadow register are cleared.
- States: IDLE, SHIFT, LATCH.
- IDLE: start=1 or auto_en=1 at an edge triggers a load. At that edge, shadow<=data, DS<=first bit, SH_CP=0, div_cnt=0, bit_cnt=0, busy<=1, state<=SHIFT.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1; each wrap ends a phase.
  - End of low phase: SH_CP<=1. The 595 samples DS on this rising edge.
  - End of high phase: SH_CP<=0.
  - If bit_cnt==NBITS-1, then ST_CP<=1 and state<=LATCH.
  - Otherwise bit_cnt++ and DS<=next bit.
  - DS changes only together with SH_CP falling, so it is stable for the full high phase.
- LATCH: ST_CP is held high for CLK_DIV cycles. Then ST_CP<=0 and done<=1 for exactly one cycle.
  - If pending=1: reload shadow from the pending buffer, clear pending, go to SHIFT with the same setup as IDLE load. busy stays 1.
  - Else if auto_en=1: reload from current data, go to SHIFT, busy stays 1.
  - Else: busy<=0, state<=IDLE.
- Busy duration for a single transaction is 2*CLK_DIV*NBITS + CLK_DIV cycles. Default: 132 cycles.
- start while busy: data is captured into the pending buffer and pending<=1. A later start while still busy overwrites the buffer (latest wins). Start is never lost and never queued deeper than one.
- start and auto_en both high in IDLE: a single load occurs.
- start in the same cycle as the LATCH exit counts as pending and is served immediately.
- data changes during SHIFT do not affect the transfer in flight; only shadow is shifted.
- Reset mid-transaction: all outputs return to reset values on the next edge and no ST_CP pulse is issued. The 595 outputs keep their previously latched value.
- MSB_FIRST=0 shifts data[0] first.
- bit_cnt width is clog2(NBITS); div_cnt width is clog2(CLK_DIV)+1.

Test Plan:
1. Defaults, data=16'hA55A, start pulse:
   - busy rises 1 cycle later and stays high for 132 cycles.
   - There are 16 SH_CP rising edges, each 8 cycles apart.
   - DS sampled at those rises reads 1,0,1,0,0,1,0,1,0,1,0,1,1,0,1,0.
   - One ST_CP pulse 4 cycles wide follows, done pulses once, and a 595 chain model holds A55A.
2. MSB_FIRST=0, NUM_CHIPS=3, CLK_DIV=1, data=24'h000001: the first DS bit sampled is 1 and the rest are 0. busy lasts 49 cycles.
3. start with data=16'h1234, then at cycle 20 start with 16'hFFFF, then at cycle 40 start with 16'h0F0F:
   - First transfer delivers 1234 with done.
   - The second transfer starts without busy dropping and delivers 0F0F.
   - FFFF is never latched.
4. auto_en=1 held, no start: back-to-back transactions run with busy continuously high and one done per 132 cycles. A data change between transactions appears in the next latch.
5. Reset asserted at cycle 50 of a transfer: next edge shows SH_CP=ST_CP=DS=busy=done=0. No ST_CP pulse occurs and the previous latched chain value is unchanged. A new start after reset works normally.
6. start and auto_en both high in IDLE: exactly one transaction begins. Dropping auto_en mid-transfer leaves the chain IDLE after done.
